barrett_stream: RTL

Parametrised, fully pipelined Barrett modular reducer with valid/ready streaming on input and output, a runtime-loadable modulus/μ configuration port, and a tag passed through alongside each operand. It is the next generation of `barrett_pipelined`. It adds four things: width generalisation, backpressure, safe reconfiguration between bursts, and normalisation checking. It sits between the NTT/multiplier datapath and downstream consumers, reducing double-width products modulo m.

---
 rtl/barrett_pkg.sv | 23 ++
 rtl/barrett_mul.sv | 40 ++++
 rtl/barrett_stream.sv | 137 +++++++++++++
 3 files changed

// File: rtl/barrett_pkg.sv
// +--------------------------------------------------------------------------+
// | barrett_pkg : shared constants and stage layout for barrett_stream        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package barrett_pkg;

    localparam int BARRETT_W_DEF     = 32;
    localparam int BARRETT_TAG_W_DEF = 4;
    localparam int BARRETT_LAT       = 3;

    // Stage-register layout at the default width; the top elaborates the same
    // fields (valid, low x bits or r, tag) sized to its own W and TAG_W.
    typedef struct packed {
        logic                         valid;
        logic [BARRETT_W_DEF+1:0]     xr;
        logic [BARRETT_TAG_W_DEF-1:0] tag;
    } barrett_stage_t;

endpackage

`default_nettype wire

// File: rtl/barrett_mul.sv
// +--------------------------------------------------------------------------+
// | barrett_mul : unsigned A x B multiplier, shifted/truncated, reg output    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module barrett_mul #(
    parameter int A_W   = 33,
    parameter int B_W   = 34,
    parameter int SHIFT = 0,
    parameter int OUT_W = 67
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    output logic [OUT_W-1:0] p_o
);

    localparam int P_W = A_W + B_W;

    logic [OUT_W-1:0] p_d;
    logic [OUT_W-1:0] p_q;

    assign p_d = OUT_W'((P_W'(a_i) * P_W'(b_i)) >> SHIFT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

`default_nettype wire

// File: rtl/barrett_stream.sv
// +--------------------------------------------------------------------------+
// | barrett_stream : 3-stage streaming Barrett reducer, x mod m, valid/ready  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module barrett_stream
    import barrett_pkg::*;
#(
    parameter int W     = BARRETT_W_DEF,
    parameter int TAG_W = BARRETT_TAG_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [W-1:0]     cfg_m_i,
    input  logic [W+1:0]     cfg_mu_i,
    output logic             cfg_err_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2*W-1:0]   x_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    typedef struct packed {
        logic             valid;
        logic [W+1:0]     xr;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t           s1_d, s1_q, s2_q, s3_d, s3_q;
    logic             out_valid_q;
    logic [W-1:0]     result_d, result_q;
    logic [TAG_W-1:0] tag_q;
    logic [W-1:0]     m_q;
    logic [W+1:0]     mu_q;
    logic             cfg_err_q;

    logic             adv, accept, cfg_accept, busy;
    logic [W+1:0]     q3, qm_lo, m_ext, r_fix1;

    assign busy       = s1_q.valid | s2_q.valid | s3_q.valid | out_valid_q;
    assign adv        = !out_valid_q || out_ready_i;
    assign in_ready_o = adv && !cfg_valid_i;
    assign accept     = in_valid_i && in_ready_o;
    assign cfg_accept = cfg_valid_i && !busy;

    // q3 = ((x >> (W-1)) * mu) >> (W+1), aligned with s1_q
    barrett_mul #(
        .A_W   (W + 1),
        .B_W   (W + 2),
        .SHIFT (W + 1),
        .OUT_W (W + 2)
    ) u_mul_q (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (adv),
        .a_i    (x_i[2*W-1:W-1]),
        .b_i    (mu_q),
        .p_o    (q3)
    );

    // Only the low W+2 bits of q3*m matter: the true remainder is below 3m.
    barrett_mul #(
        .A_W   (W + 2),
        .B_W   (W),
        .SHIFT (0),
        .OUT_W (W + 2)
    ) u_mul_qm (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (adv),
        .a_i    (q3),
        .b_i    (m_q),
        .p_o    (qm_lo)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.valid = accept;
        s1_d.xr    = x_i[W+1:0];
        s1_d.tag   = tag_i;

        s3_d       = s2_q;
        s3_d.xr    = s2_q.xr - qm_lo;

        m_ext      = {2'b00, m_q};
        r_fix1     = (s3_q.xr >= m_ext) ? (s3_q.xr - m_ext) : s3_q.xr;
        result_d   = (r_fix1 >= m_ext) ? W'(r_fix1 - m_ext) : W'(r_fix1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            tag_q       <= '0;
            m_q         <= '0;
            mu_q        <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            if (adv) begin
                s1_q        <= s1_d;
                s2_q        <= s1_q;
                s3_q        <= s3_d;
                out_valid_q <= s3_q.valid;
                if (s3_q.valid) begin
                    result_q <= result_d;
                    tag_q    <= s3_q.tag;
                end
            end
            if (cfg_accept) begin
                m_q       <= cfg_m_i;
                mu_q      <= cfg_mu_i;
                cfg_err_q <= !cfg_m_i[W-1];
            end
        end
    end

    assign cfg_ready_o = cfg_accept;
    assign cfg_err_o   = cfg_err_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign tag_o       = tag_q;
    assign busy_o      = busy;

endmodule

`default_nettype wire
